// File: rtl/fsm_product_serializer.sv
// fsm_product_serializer: accepts a 256-bit matrix product, XORs it with the
// first-round hash and emits the result as a burst of four 64-bit words to
// the downstream hash-packing stage, with a minimum idle gap between bursts.
// Optional feature: define PRODUCT_SERIALIZER_BSWAP_EN to byte-reverse every
// emitted word.
module fsm_product_serializer #(
  parameter int unsigned MIN_GAP = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         prod_valid,
  input  logic [255:0] prod_data,
  input  logic [255:0] hash_data,
  output logic         prod_ready,
  input  logic         ds_rdy,
  output logic         we_out,
  output logic [63:0]  dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EMIT0 = 3'd1,
    EMIT1 = 3'd2,
    EMIT2 = 3'd3,
    EMIT3 = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           full_q, full_d;
  logic [3:0]     gap_cnt_q, gap_cnt_d;
  logic [255:0]   data_reg_q, data_reg_d;
  logic           we_out_q, we_out_d;
  logic [63:0]    dout_q, dout_d;
  logic           accept;
  logic           gap_done;
  logic [63:0]    word_sel;

`ifdef PRODUCT_SERIALIZER_BSWAP_EN
  function automatic logic [63:0] fmt_word(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      r[8*b +: 8] = w[8*(7-b) +: 8];
    end
    return r;
  endfunction
`else
  function automatic logic [63:0] fmt_word(input logic [63:0] w);
    return w;
  endfunction
`endif

  // Handshake, next-state, gap counter, data holding and next outputs.
  always_comb begin
    prod_ready = ~rst & (~full_q | (state_q == EMIT3));
    accept     = prod_valid & prod_ready;
    // Gap counts as elapsed when the counter reaches 0 on this edge, giving
    // exactly MIN_GAP idle cycles between EMIT3 and the next EMIT0.
    gap_done   = (gap_cnt_q <= 4'd1);

    state_d    = state_q;
    full_d     = full_q;
    gap_cnt_d  = gap_cnt_q;
    data_reg_d = data_reg_q;

    case (state_q)
      IDLE: begin
        gap_cnt_d = (gap_cnt_q == 4'd0) ? 4'd0 : gap_cnt_q - 4'd1;
        if (full_q && ds_rdy && gap_done) begin
          state_d = EMIT0;
        end
      end
      EMIT0: state_d = EMIT1;
      EMIT1: state_d = EMIT2;
      EMIT2: state_d = EMIT3;
      EMIT3: begin
        state_d   = IDLE;
        full_d    = 1'b0;
        gap_cnt_d = 4'(MIN_GAP);
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      data_reg_d = prod_data ^ hash_data;
      full_d     = 1'b1;
    end

    word_sel = '0;
    case (state_d)
      EMIT0:   word_sel = data_reg_q[63:0];
      EMIT1:   word_sel = data_reg_q[127:64];
      EMIT2:   word_sel = data_reg_q[191:128];
      EMIT3:   word_sel = data_reg_q[255:192];
      default: word_sel = '0;
    endcase

    we_out_d = (state_d != IDLE);
    dout_d   = we_out_d ? fmt_word(word_sel) : '0;
  end

  // State, holding registers and registered outputs; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      full_q     <= 1'b0;
      gap_cnt_q  <= '0;
      data_reg_q <= '0;
      we_out_q   <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      gap_cnt_q  <= gap_cnt_d;
      data_reg_q <= data_reg_d;
      we_out_q   <= we_out_d;
      dout_q     <= dout_d;
    end
  end

  assign we_out = we_out_q;
  assign dout   = dout_q;

endmodule

// File: tb/tb_fsm_product_serializer.sv
// Directed bench for fsm_product_serializer: table of single-product vectors
// plus hand-written sequences for back-to-back, downstream stall and reset.
module tb_fsm_product_serializer;

  logic         clk;
  logic         rst;
  logic         prod_valid;
  logic [255:0] prod_data;
  logic [255:0] hash_data;
  logic         prod_ready;
  logic         ds_rdy;
  logic         we_out;
  logic [63:0]  dout;

  int n_cmp;
  int n_err;

  fsm_product_serializer #(.MIN_GAP(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .hash_data  (hash_data),
    .prod_ready (prod_ready),
    .ds_rdy     (ds_rdy),
    .we_out     (we_out),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [255:0]          prod;
    logic [255:0]          hash;
    logic [3:0][63:0]      words;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [63:0] exp_word(input logic [63:0] w);
`ifdef PRODUCT_SERIALIZER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24],
            w[39:32], w[47:40], w[55:48], w[63:56]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Apply one product with ds_rdy high and check the four-word burst.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    ds_rdy     = 1'b1;
    prod_data  = v.prod;
    hash_data  = v.hash;
    check({tag, " ready"}, {63'd0, prod_ready}, 64'd1);
    prod_valid = 1'b1;
    @(posedge clk);
    #1 prod_valid = 1'b0;
    @(negedge clk);
    check({tag, " we pre"}, {63'd0, we_out}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, " we"}, {63'd0, we_out}, 64'd1);
      check({tag, " dout"}, dout, exp_word(v.words[k]));
    end
    @(negedge clk);
    check({tag, " we post"}, {63'd0, we_out}, 64'd0);
    check({tag, " dout post"}, dout, 64'd0);
    idle_cycles(8);
  endtask

  initial begin
    logic [255:0] pa, pb, hh;
    logic [63:0]  exp8[8];
    int           wcnt, gap, cyc, stray;
    logic         drop;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    prod_valid = 1'b0;
    prod_data = '0;
    hash_data = '0;
    ds_rdy = 1'b0;

    vecs[0].prod  = '0;
    vecs[0].hash  = {64'h4, 64'h3, 64'h2, 64'h1};
    vecs[0].words = {64'h4, 64'h3, 64'h2, 64'h1};
    vecs[1].prod  = '1;
    vecs[1].hash  = '1;
    vecs[1].words = {64'h0, 64'h0, 64'h0, 64'h0};
    vecs[2].prod  = {64'h0, 64'h0, 64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0};
    vecs[2].hash  = {64'hDEAD_BEEF_0000_0000, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h1111_1111_1111_1111};
    vecs[2].words = {64'hDEAD_BEEF_0000_0000, 64'h0, 64'hF0F0_0F0F_F0F0_0F0F, 64'h0325_4769_8BAD_CFE1};
    vecs[3].prod  = '0;
    vecs[3].hash  = {64'h0, 64'h0, 64'h0, 64'h0102_0304_0506_0708};
    vecs[3].words = {64'h0, 64'h0, 64'h0, 64'h0102_0304_0506_0708};

    // Reset state
    idle_cycles(3);
    check("rst ready", {63'd0, prod_ready}, 64'd0);
    check("rst we", {63'd0, we_out}, 64'd0);
    check("rst dout", dout, 64'd0);
    rst = 1'b0;
    #1 check("ready after rst", {63'd0, prod_ready}, 64'd1);
    idle_cycles(2);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef PRODUCT_SERIALIZER_BSWAP_EN
    check("bswap const", exp_word(64'h0102_0304_0506_0708), 64'h0807_0605_0403_0201);
`endif

    // Back-to-back with prod_valid held: second accept on EMIT3 edge, 6 idle cycles
    pa = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    pb = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
    hh = {64'h0F00, 64'h0F00, 64'h0F00, 64'h0F00};
    for (int k = 0; k < 4; k++) exp8[k]   = pa[64*k +: 64] ^ 64'h0F00;
    for (int k = 0; k < 4; k++) exp8[k+4] = pb[64*k +: 64] ^ 64'h0F00;
    @(negedge clk);
    ds_rdy = 1'b1;
    hash_data = hh;
    prod_data = pa;
    prod_valid = 1'b1;
    @(posedge clk);
    #1 prod_data = pb;
    wcnt = 0; gap = 0; drop = 1'b0;
    for (cyc = 0; cyc < 40 && wcnt < 8; cyc++) begin
      @(negedge clk);
      if (drop) begin
        prod_valid = 1'b0;
        drop = 1'b0;
      end
      if (we_out) begin
        check($sformatf("b2b word%0d", wcnt), dout, exp_word(exp8[wcnt]));
        wcnt++;
        if (wcnt == 4) begin
          check("b2b ready emit3", {63'd0, prod_ready}, 64'd1);
          drop = 1'b1;
        end
        if (wcnt == 5) check("b2b gap", 64'(gap), 64'd6);
      end else if (wcnt == 4) begin
        gap++;
      end
    end
    check("b2b words", 64'(wcnt), 64'd8);
    prod_valid = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (we_out) stray++;
    end
    check("b2b no dup", 64'(stray), 64'd0);

    // Downstream stall for 10 cycles, then ds_rdy toggled mid-burst
    @(negedge clk);
    ds_rdy = 1'b0;
    prod_data = {64'h44, 64'h33, 64'h22, 64'h11};
    hash_data = '0;
    prod_valid = 1'b1;
    @(posedge clk);
    #1 prod_valid = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (we_out) stray++;
    end
    check("stall no we", 64'(stray), 64'd0);
    check("stall ready", {63'd0, prod_ready}, 64'd0);
    ds_rdy = 1'b1;
    @(negedge clk);
    check("stall start we", {63'd0, we_out}, 64'd1);
    check("stall w0", dout, exp_word(64'h11));
    ds_rdy = 1'b0;
    @(negedge clk);
    check("stall w1", dout, exp_word(64'h22));
    @(negedge clk);
    check("stall w2", dout, exp_word(64'h33));
    @(negedge clk);
    check("stall w3 we", {63'd0, we_out}, 64'd1);
    check("stall w3", dout, exp_word(64'h44));
    @(negedge clk);
    check("stall end we", {63'd0, we_out}, 64'd0);
    ds_rdy = 1'b1;
    idle_cycles(8);

    // Reset pulsed during EMIT1
    @(negedge clk);
    prod_data = {64'h9, 64'h8, 64'h7, 64'h6};
    hash_data = '0;
    prod_valid = 1'b1;
    @(posedge clk);
    #1 prod_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst0 w0", dout, exp_word(64'h6));
    @(negedge clk);
    check("rst1 we", {63'd0, we_out}, 64'd1);
    #2 rst = 1'b1;
    #1 check("rst async we", {63'd0, we_out}, 64'd0);
    check("rst async dout", dout, 64'd0);
    check("rst async ready", {63'd0, prod_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (we_out) stray++;
    end
    check("rst no resume", 64'(stray), 64'd0);
    check("rst ready back", {63'd0, prod_ready}, 64'd1);

    // New acceptance after reset works again
    run_vec(vecs[0], "post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
